// File: rtl/ram_bank_router.sv
// ram_bank_router: decodes host requests onto four RAM banks and returns read
// data in request order through a credit-protected response FIFO.
`default_nettype none

module ram_bank_router #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 12,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W+1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic [3:0]            bank_write,
  output logic [3:0]            bank_read,
  output logic [4*ADDR_W-1:0]   bank_wr_addr,
  output logic [4*ADDR_W-1:0]   bank_rd_addr,
  output logic [4*DATA_W-1:0]   bank_wdata,
  input  logic [4*DATA_W-1:0]   bank_rdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data
);

  localparam int c_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [3:0]          r_bank_write;
  logic [3:0]          r_bank_read;
  logic [4*ADDR_W-1:0] r_wr_addr;
  logic [4*ADDR_W-1:0] r_rd_addr;
  logic [4*DATA_W-1:0] r_wdata;
  logic                r_iss_rd;
  logic [1:0]          r_iss_bank;
  logic                r_cap_rd;
  logic [1:0]          r_cap_bank;

  logic [DATA_W-1:0]   r_mem [RSP_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [DATA_W-1:0]   r_hold;

  logic                w_accept;
  logic [1:0]          w_bank;
  logic                w_push;
  logic                w_pop;
  logic                w_empty;
  logic [c_CNT_W:0]    w_outstanding;
  logic [DATA_W-1:0]   w_cap_data;

  assign w_bank  = req_addr[ADDR_W+1:ADDR_W];
  assign w_empty = (r_count == '0);

  // Credits count FIFO entries plus reads still travelling toward it, so a
  // push can never land on a full FIFO.
  assign w_outstanding = {1'b0, r_count}
                       + {{c_CNT_W{1'b0}}, r_iss_rd}
                       + {{c_CNT_W{1'b0}}, r_cap_rd};
  assign req_ready = (w_outstanding < (c_CNT_W+1)'(RSP_DEPTH));
  assign w_accept  = req_valid & req_ready;

  assign w_push     = r_cap_rd;
  assign w_pop      = rsp_valid & rsp_ready;
  assign w_cap_data = bank_rdata[r_cap_bank*DATA_W +: DATA_W];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_bank_write <= '0;
      r_bank_read  <= '0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_wdata      <= '0;
      r_iss_rd     <= 1'b0;
      r_iss_bank   <= '0;
      r_cap_rd     <= 1'b0;
      r_cap_bank   <= '0;
    end else begin
      r_bank_write <= '0;
      r_bank_read  <= '0;
      r_iss_rd     <= 1'b0;
      if (w_accept) begin
        for (int b = 0; b < 4; b++) begin
          if (w_bank == 2'(b)) begin
            if (req_write) begin
              r_bank_write[b]                   <= 1'b1;
              r_wr_addr[b*ADDR_W +: ADDR_W]     <= req_addr[ADDR_W-1:0];
              r_wdata[b*DATA_W +: DATA_W]       <= req_wdata;
            end else begin
              r_bank_read[b]                    <= 1'b1;
              r_rd_addr[b*ADDR_W +: ADDR_W]     <= req_addr[ADDR_W-1:0];
            end
          end
        end
        if (!req_write) begin
          r_iss_rd   <= 1'b1;
          r_iss_bank <= w_bank;
        end
      end
      r_cap_rd   <= r_iss_rd;
      r_cap_bank <= r_iss_bank;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_cap_data;
        r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_hold   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // An empty FIFO keeps presenting the most recently consumed word.
  assign rsp_valid    = !w_empty;
  assign rsp_data     = w_empty ? r_hold : r_mem[r_rd_ptr];
  assign bank_write   = r_bank_write;
  assign bank_read    = r_bank_read;
  assign bank_wr_addr = r_wr_addr;
  assign bank_rd_addr = r_rd_addr;
  assign bank_wdata   = r_wdata;

endmodule

`default_nettype wire
